hash_stream: RTL and testbench

HASH_STREAM -- requirements
Module: hash_stream

---
 rtl/hash_stream_pkg.sv | 18 +
 rtl/hash_stream_round.sv | 16 +
 rtl/hash_stream.sv | 105 ++++++++++
 tb/tb_hash_stream.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hash_stream_pkg.sv
// Shared constants and types for the byte-stream hasher and any other hash stages.
package hash_stream_pkg;

  localparam int unsigned HASH_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ROT_W  = 5;

  localparam logic [HASH_W-1:0] HASH_ADD = 16'h9E37;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ABSORB = 2'd1,
    FINAL  = 2'd2,
    HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/hash_stream_round.sv
// One combinational hash round: h_next = (rotl(h) ^ byte) + HASH_ADD.
// Ports: h_i (current hash), byte_i (message byte), h_next_o (updated hash).
module hash_round
  import hash_stream_pkg::*;
(
  input  logic [HASH_W-1:0] h_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [HASH_W-1:0] h_next_o
);

  logic [HASH_W-1:0] rot;

  assign rot      = {h_i[HASH_W-ROT_W-1:0], h_i[HASH_W-1:HASH_W-ROT_W]};
  assign h_next_o = (rot ^ HASH_W'(byte_i)) + HASH_ADD;

endmodule

// File: rtl/hash_stream.sv
// Byte-stream hasher: absorbs a message byte-by-byte, then presents a held
// 16-bit digest until acknowledged.
// Ports: clk, reset (async active-low), data_in/data_valid/data_last (byte
// stream in), data_ready (combinational accept), digest/digest_valid/
// digest_ack (result handshake), busy (not IDLE), len_err (truncated at MAX_LEN).
module hash_stream
  import hash_stream_pkg::*;
#(
  parameter logic [HASH_W-1:0] INIT    = 16'hACE1,
  parameter logic [CNT_W-1:0]  MAX_LEN = 8'd255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              data_last,
  output logic              data_ready,
  output logic [HASH_W-1:0] digest,
  output logic              digest_valid,
  input  logic              digest_ack,
  output logic              busy,
  output logic              len_err
);

  state_e            state_q, state_d;
  logic [HASH_W-1:0] h_q, h_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [HASH_W-1:0] digest_q, digest_d;
  logic              len_err_q, len_err_d;
  logic [HASH_W-1:0] h_next;
  logic              accept;

  hash_round u_round (
    .h_i      (h_q),
    .byte_i   (data_in),
    .h_next_o (h_next)
  );

  // Ready purely from state so it is already high in IDLE while reset is held.
  assign data_ready = (state_q == IDLE) || (state_q == ABSORB);
  assign accept     = data_valid && data_ready;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      h_q       <= INIT;
      count_q   <= '0;
      digest_q  <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      count_q   <= count_d;
      digest_q  <= digest_d;
      len_err_q <= len_err_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    count_d   = count_q;
    digest_d  = digest_q;
    len_err_d = len_err_q;
    unique case (state_q)
      IDLE, ABSORB: begin
        if (accept) begin
          h_d     = h_next;
          count_d = CNT_W'(count_q + CNT_W'(1));
          if (data_last) begin
            state_d = FINAL;
          end else if (count_d == MAX_LEN) begin
            // Message hit the length cap without a last flag: truncate it.
            state_d   = FINAL;
            len_err_d = 1'b1;
          end else begin
            state_d = ABSORB;
          end
        end
      end
      FINAL: begin
        digest_d = h_q ^ HASH_W'(count_q);
        state_d  = HOLD;
      end
      HOLD: begin
        if (digest_ack) begin
          // Re-seed on the way back to IDLE; digest keeps its old value.
          state_d   = IDLE;
          h_d       = INIT;
          count_d   = '0;
          len_err_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign digest       = digest_q;
  assign digest_valid = (state_q == HOLD);
  assign busy         = (state_q != IDLE);
  assign len_err      = len_err_q;

endmodule

// File: tb/tb_hash_stream.sv
// Directed self-checking bench for hash_stream (default and MAX_LEN=4 builds).
module tb_hash_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        data_valid, data_last, digest_ack;
  logic        data_ready, digest_valid, busy, len_err;
  logic [15:0] digest;

  logic [7:0]  d4_in;
  logic        d4_valid, d4_last, d4_ack;
  logic        d4_ready, d4_dvalid, d4_busy, d4_len_err;
  logic [15:0] d4_digest;

  int tests = 0;
  int fails = 0;
  logic [7:0]  msg [8];
  logic [15:0] exp_d;
  logic [15:0] held;

  always #5 clk = ~clk;

  hash_stream dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_last(data_last), .data_ready(data_ready), .digest(digest),
    .digest_valid(digest_valid), .digest_ack(digest_ack), .busy(busy),
    .len_err(len_err)
  );

  hash_stream #(.MAX_LEN(8'd4)) dut4 (
    .clk(clk), .reset(reset), .data_in(d4_in), .data_valid(d4_valid),
    .data_last(d4_last), .data_ready(d4_ready), .digest(d4_digest),
    .digest_valid(d4_dvalid), .digest_ack(d4_ack), .busy(d4_busy),
    .len_err(d4_len_err)
  );

  // Reference: shift-based rotate, independent of the RTL slicing.
  function automatic logic [15:0] model(input int n);
    logic [15:0] h;
    logic [15:0] r;
    h = 16'hACE1;
    for (int i = 0; i < n; i++) begin
      r = (h << 5) | (h >> 11);
      h = (r ^ {8'h00, msg[i]}) + 16'h9E37;
    end
    return h ^ 16'(n);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    chk("ready_before_send", 16'(data_ready), 16'h1);
    data_in    = b;
    data_last  = last;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    data_last  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; data_in = '0; data_valid = 0; data_last = 0; digest_ack = 0;
    d4_in = '0; d4_valid = 0; d4_last = 0; d4_ack = 0;
    #1;
    chk("rst_digest", digest, 16'h0000);
    chk("rst_dvalid", 16'(digest_valid), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_len_err", 16'(len_err), 16'h0);
    chk("rst_ready", 16'(data_ready), 16'h1);
    tick(); tick();
    reset = 1'b1;

    // Single 0x00 byte right after reset release.
    send(8'h00, 1'b1);
    chk("single_final_dvalid", 16'(digest_valid), 16'h0);
    chk("single_final_ready", 16'(data_ready), 16'h0);
    chk("single_final_busy", 16'(busy), 16'h1);
    tick();
    chk("single_dvalid", 16'(digest_valid), 16'h1);
    chk("single_digest", digest, 16'h3A6D);
    chk("single_len_err", 16'(len_err), 16'h0);
    digest_ack = 1'b1;
    tick();
    digest_ack = 1'b0;
    chk("ack_dvalid_low", 16'(digest_valid), 16'h0);
    chk("ack_busy_low", 16'(busy), 16'h0);
    chk("digest_retained", digest, 16'h3A6D);

    // Three bytes with gaps; last flag toggled while invalid must be ignored.
    msg[0] = 8'h41; msg[1] = 8'h42; msg[2] = 8'h43;
    send(msg[0], 1'b0);
    data_last = 1'b1; tick(); tick(); data_last = 1'b0;
    chk("gap_busy", 16'(busy), 16'h1);
    chk("gap_dvalid", 16'(digest_valid), 16'h0);
    send(msg[1], 1'b0);
    tick();
    send(msg[2], 1'b1);
    chk("three_final_ready", 16'(data_ready), 16'h0);
    tick();
    exp_d = model(3);
    chk("three_digest", digest, exp_d);
    chk("three_dvalid", 16'(digest_valid), 16'h1);

    // Hold without ack while a byte is offered: nothing moves.
    data_valid = 1'b1; data_in = 8'hFF; data_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_dvalid", 16'(digest_valid), 16'h1);
      chk("hold_digest", digest, exp_d);
      chk("hold_ready", 16'(data_ready), 16'h0);
    end
    data_valid = 1'b0; data_last = 1'b0;
    digest_ack = 1'b1;
    tick();
    digest_ack = 1'b0;
    msg[0] = 8'h5A;
    send(msg[0], 1'b1);
    tick();
    chk("after_hold_digest", digest, model(1));

    // Back-to-back: ack edge, then a new byte on the very next edge.
    digest_ack = 1'b1;
    tick();
    digest_ack = 1'b0;
    msg[0] = 8'h01; msg[1] = 8'h02;
    send(msg[0], 1'b0);
    send(msg[1], 1'b1);
    tick();
    chk("b2b_digest", digest, model(2));
    chk("b2b_len_err", 16'(len_err), 16'h0);

    // Reset mid-message discards it.
    digest_ack = 1'b1;
    tick();
    digest_ack = 1'b0;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    reset = 1'b0;
    #1;
    chk("midrst_busy", 16'(busy), 16'h0);
    chk("midrst_digest", digest, 16'h0000);
    chk("midrst_ready", 16'(data_ready), 16'h1);
    tick();
    reset = 1'b1;
    send(8'h00, 1'b1);
    tick();
    chk("postrst_digest", digest, 16'h3A6D);
    chk("postrst_dvalid", 16'(digest_valid), 16'h1);
    digest_ack = 1'b1;
    tick();
    digest_ack = 1'b0;

    // MAX_LEN=4 instance: six bytes, no last flag.
    for (int i = 0; i < 4; i++) msg[i] = 8'(i + 1);
    d4_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d4_in = msg[i];
      chk("ml_ready", 16'(d4_ready), 16'h1);
      tick();
    end
    d4_in = 8'h05;
    chk("ml_final_ready", 16'(d4_ready), 16'h0);
    chk("ml_len_err", 16'(d4_len_err), 16'h1);
    tick();
    exp_d = model(4);
    chk("ml_dvalid", 16'(d4_dvalid), 16'h1);
    chk("ml_digest", d4_digest, exp_d);
    d4_in = 8'h06;
    held = d4_digest;
    tick();
    chk("ml_hold_ready", 16'(d4_ready), 16'h0);
    chk("ml_hold_digest", d4_digest, exp_d);
    d4_valid = 1'b0;
    d4_ack = 1'b1;
    tick();
    d4_ack = 1'b0;
    chk("ml_len_err_clr", 16'(d4_len_err), 16'h0);
    chk("ml_ack_dvalid", 16'(d4_dvalid), 16'h0);
    chk("ml_retained", d4_digest, held);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
